rst_seq_hme: RTL and testbench

- Reset sequencer that sits directly downstream of the FDPE_HME-based asynchronous reset/preset flops.
- Turns a raw PLL LOCKED and a software reset request into staged, glitch-free resets for the DRAM PHY and then the controller.
- Holds both resets asserted until lock has been stable for a programmable time, then releases PHY first and controller after a delay.
- Any lock loss or SW_RST re-enters the full sequence.

---
 rtl/rst_pkg.sv | 33 +++
 rtl/sync_chain_hme.sv | 24 ++
 rtl/rst_seq_hme.sv | 122 ++++++++++++
 tb/tb_rst_seq_hme.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared types, defaults and width helpers for the staged DRAM reset sequencer.
package rst_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        PHY_UP    = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_LOCK_CYCLES = 256;
    localparam int DEF_CTRL_DLY    = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_chain_hme.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared to RST_VAL by reset.
module sync_chain_hme #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_hme.sv
// Staged reset sequencer: holds PHY and controller in reset until PLL lock is stable,
// then releases the PHY first and the controller after a fixed delay.
module rst_seq_hme
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int CTRL_DLY    = DEF_CTRL_DLY
) (
    input  logic       C,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       LOCKED,
    input  logic       SW_RST,
    output logic       RST_PHY,
    output logic       RST_CTRL,
    output logic       READY,
    output logic [1:0] STATE
);

    localparam int CNT_W = clog2(max3(HOLD_CYCLES, LOCK_CYCLES, CTRL_DLY)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(CTRL_DLY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_s;
    logic             rst_phy_q, rst_ctrl_q, ready_q;

    sync_chain_hme #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk_i  (C),
        .rst_ni (RST_N),
        .d_i    (LOCKED),
        .q_o    (locked_s)
    );

    // Aborts (SW_RST, lock loss) bypass CE; only forward progress waits for CE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if (SW_RST) begin
                    cnt_d = '0;
                end else if (CE) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_LOCK: begin
                if (SW_RST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    cnt_d = '0;
                end else if (CE) begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = PHY_UP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PHY_UP: begin
                if (SW_RST || !locked_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (CE) begin
                    if (cnt_q == CTRL_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = '0;
                if (SW_RST || !locked_s) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            rst_phy_q  <= 1'b1;
            rst_ctrl_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_phy_q  <= (state_d == HOLD) || (state_d == WAIT_LOCK);
            rst_ctrl_q <= (state_d != RUN);
            ready_q    <= (state_d == RUN);
        end
    end

    assign RST_PHY  = rst_phy_q;
    assign RST_CTRL = rst_ctrl_q;
    assign READY    = ready_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_rst_seq_hme.sv
// Directed bench for rst_seq_hme with a progress-based reference model checked every cycle.
module tb_rst_seq_hme;

    localparam int SS  = 2;
    localparam int HC  = 4;
    localparam int LC  = 16;
    localparam int CD  = 8;
    localparam int TOT = HC + LC + CD;

    logic       C = 1'b0;
    logic       RST_N;
    logic       CE;
    logic       LOCKED;
    logic       SW_RST;
    logic       RST_PHY;
    logic       RST_CTRL;
    logic       READY;
    logic [1:0] STATE;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    rst_seq_hme #(
        .SYNC_STAGES (SS),
        .HOLD_CYCLES (HC),
        .LOCK_CYCLES (LC),
        .CTRL_DLY    (CD)
    ) dut (
        .C        (C),
        .RST_N    (RST_N),
        .CE       (CE),
        .LOCKED   (LOCKED),
        .SW_RST   (SW_RST),
        .RST_PHY  (RST_PHY),
        .RST_CTRL (RST_CTRL),
        .READY    (READY),
        .STATE    (STATE)
    );

    always #5 C = ~C;

    // Model: m_t is the number of qualified cycles of progress toward RUN;
    // the phase is just which window of HOLD / LOCK / CTRL that count lies in.
    int          m_t;
    logic [SS-1:0] m_sync;
    logic        m_ls;
    assign m_ls = m_sync[SS-1];

    function automatic int phase_of(input int t);
        if (t < HC) return 0;
        if (t < HC + LC) return 1;
        if (t < TOT) return 2;
        return 3;
    endfunction

    always @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            m_t    <= 0;
            m_sync <= '0;
        end else begin
            m_sync <= {m_sync[SS-2:0], LOCKED};
            if (SW_RST) begin
                m_t <= 0;
            end else if (!m_ls && m_t >= HC) begin
                m_t <= (m_t < HC + LC) ? HC : 0;
            end else if (CE && m_t < TOT) begin
                m_t <= m_t + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge C) begin
        chk("model_STATE",    int'(STATE),    phase_of(m_t));
        chk("model_RST_PHY",  int'(RST_PHY),  int'(phase_of(m_t) < 2));
        chk("model_RST_CTRL", int'(RST_CTRL), int'(phase_of(m_t) < 3));
        chk("model_READY",    int'(READY),    int'(phase_of(m_t) == 3));
    end

    task automatic edges(input int n);
        repeat (n) @(negedge C);
    endtask

    task automatic do_reset();
        @(negedge C);
        #1 RST_N = 1'b0;
        edges(2);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N  = 1'b0;
        CE     = 1'b1;
        LOCKED = 1'b1;
        SW_RST = 1'b0;
        edges(3);
        chk("rst_STATE",    int'(STATE),    0);
        chk("rst_RST_PHY",  int'(RST_PHY),  1);
        chk("rst_RST_CTRL", int'(RST_CTRL), 1);
        chk("rst_READY",    int'(READY),    0);
        RST_N = 1'b1;
        $display("power-up sequence");

        edges(3);  chk("pu_state_e3",  int'(STATE), 0);
        edges(1);  chk("pu_state_e4",  int'(STATE), 1);
        edges(15); chk("pu_phy_e19",   int'(RST_PHY), 1);
        edges(1);  chk("pu_phy_e20",   int'(RST_PHY), 0);
                   chk("pu_ctrl_e20",  int'(RST_CTRL), 1);
        edges(7);  chk("pu_ctrl_e27",  int'(RST_CTRL), 1);
        edges(1);  chk("pu_ctrl_e28",  int'(RST_CTRL), 0);
                   chk("pu_ready_e28", int'(READY), 1);

        $display("lock loss in RUN");
        LOCKED = 1'b0;
        edges(2);  chk("ll_state_e2", int'(STATE), 3);
        edges(1);  chk("ll_state_e3", int'(STATE), 0);
                   chk("ll_phy_e3",   int'(RST_PHY), 1);
                   chk("ll_ready_e3", int'(READY), 0);
        LOCKED = 1'b1;
        edges(27); chk("ll_ready_e27", int'(READY), 0);
        edges(1);  chk("ll_ready_e28", int'(READY), 1);

        $display("lock glitch in WAIT_LOCK");
        do_reset();
        edges(14); chk("lg_state_e14", int'(STATE), 1);
        LOCKED = 1'b0;
        edges(3);
        LOCKED = 1'b1;
        edges(17); chk("lg_state_e34", int'(STATE), 1);
                   chk("lg_phy_e34",   int'(RST_PHY), 1);
        edges(1);  chk("lg_phy_e35",   int'(RST_PHY), 0);

        $display("SW_RST pulse in PHY_UP");
        do_reset();
        edges(22); chk("sw_state_pre", int'(STATE), 2);
        SW_RST = 1'b1;
        edges(1);
        SW_RST = 1'b0;
        chk("sw_state", int'(STATE), 0);
        chk("sw_phy",   int'(RST_PHY), 1);
        edges(22); chk("swce_state_pre", int'(STATE), 2);
        CE = 1'b0;
        SW_RST = 1'b1;
        edges(1);
        SW_RST = 1'b0;
        chk("swce_state", int'(STATE), 0);
        chk("swce_phy",   int'(RST_PHY), 1);
        CE = 1'b1;
        edges(28); chk("swh_ready_pre", int'(READY), 1);
        SW_RST = 1'b1;
        edges(10); chk("swh_state_e10", int'(STATE), 0);
        SW_RST = 1'b0;
        edges(3);  chk("swh_state_e13", int'(STATE), 0);
        edges(1);  chk("swh_state_e14", int'(STATE), 1);

        $display("CE toggling");
        CE = 1'b1;
        do_reset();
        for (int i = 1; i <= 56; i++) begin
            edges(1);
            CE = ~CE;
            if (i == 38) chk("ce_phy_e38",   int'(RST_PHY), 1);
            if (i == 39) chk("ce_phy_e39",   int'(RST_PHY), 0);
            if (i == 54) chk("ce_ready_e54", int'(READY), 0);
            if (i == 55) chk("ce_ready_e55", int'(READY), 1);
        end
        CE = 1'b1;

        $display("async reset in PHY_UP");
        do_reset();
        edges(23); chk("ar_state_pre", int'(STATE), 2);
        #2 RST_N = 1'b0;
        #1;
        chk("ar_state", int'(STATE),    0);
        chk("ar_phy",   int'(RST_PHY),  1);
        chk("ar_ctrl",  int'(RST_CTRL), 1);
        chk("ar_ready", int'(READY),    0);
        edges(1);
        RST_N = 1'b1;
        edges(28); chk("ar_ready_e28", int'(READY), 1);

        edges(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
